// File: rtl/top_module_hls_deadlock_report_unit.sv
// Deadlock report unit: picks an origin process, traces the token loop,
// clears the origin token and posts a report until software acknowledges.
module top_module_hls_deadlock_report_unit #(
    parameter int PROC_NUM = 4,
    parameter int LEN_W    = 8,
    parameter int TIMEOUT  = 1023
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] token_ret_vec,
    input  logic                dl_ack,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic [PROC_NUM-1:0] token_clear,
    output logic                dl_detect_global,
    output logic                dl_report_vld,
    output logic [PROC_NUM-1:0] dl_report_proc,
    output logic [LEN_W-1:0]    dl_report_len,
    output logic                dl_report_timeout
);

    localparam int ID_W = $clog2(PROC_NUM);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ORIGIN, TRACE, CLEAR, REPORT, HOLD} state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     org_id, low_id;
    logic [TO_W-1:0]     to_cnt;
    logic [LEN_W-1:0]    len_inc;
    logic [PROC_NUM-1:0] org_onehot;
    logic                ret_hit, to_hit;

    // Lowest-index requester wins the origin slot
    always_comb begin
        low_id = '0;
        for (int unsigned i = PROC_NUM; i > 0; i--) begin
            if (dl_detect_vec[i-1]) low_id = ID_W'(i - 1);
        end
    end

    always_comb begin
        len_inc    = (&dl_report_len) ? dl_report_len : dl_report_len + 1'b1;
        org_onehot = PROC_NUM'(1) << org_id;
        ret_hit    = token_ret_vec[org_id];
        to_hit     = (to_cnt == TO_W'(TIMEOUT - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|dl_detect_vec) state_nxt = ORIGIN;
            ORIGIN:  state_nxt = TRACE;
            TRACE:   if (ret_hit || to_hit) state_nxt = CLEAR;
            CLEAR:   state_nxt = REPORT;
            REPORT:  if (dl_ack) state_nxt = HOLD;
            HOLD:    if (dl_detect_vec == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            org_id            <= '0;
            to_cnt            <= '0;
            origin_vec        <= '0;
            token_clear       <= '0;
            dl_detect_global  <= 1'b0;
            dl_report_vld     <= 1'b0;
            dl_report_proc    <= '0;
            dl_report_len     <= '0;
            dl_report_timeout <= 1'b0;
        end else begin
            state            <= state_nxt;
            // Strobes are registered from the next state so they line up with it
            dl_detect_global <= (state_nxt != IDLE);
            dl_report_vld    <= (state_nxt == REPORT);
            token_clear      <= (state_nxt == CLEAR) ? org_onehot : '0;
            origin_vec       <= '0;
            if (state == IDLE && state_nxt == ORIGIN) begin
                org_id     <= low_id;
                origin_vec <= PROC_NUM'(1) << low_id;
            end
            case (state)
                ORIGIN: begin
                    dl_report_proc    <= org_onehot;
                    dl_report_len     <= '0;
                    dl_report_timeout <= 1'b0;
                    to_cnt            <= '0;
                end
                TRACE: begin
                    dl_report_proc <= dl_report_proc | token_ret_vec;
                    dl_report_len  <= len_inc;
                    to_cnt         <= to_cnt + 1'b1;
                    if (!ret_hit && to_hit) dl_report_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_top_module_hls_deadlock_report_unit.sv
// Directed bench for the deadlock report unit with a report scoreboard.
module tb_top_module_hls_deadlock_report_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] dl_detect_vec, token_ret_vec;
    logic       dl_ack;
    logic [3:0] origin_vec, token_clear, dl_report_proc;
    logic       dl_detect_global, dl_report_vld, dl_report_timeout;
    logic [7:0] dl_report_len;

    typedef struct {
        logic [3:0] proc;
        logic [7:0] len;
        logic       to;
    } rpt_t;

    rpt_t q[$];
    int   total = 0;
    int   bad   = 0;

    top_module_hls_deadlock_report_unit #(.PROC_NUM(4), .LEN_W(8), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .dl_detect_vec(dl_detect_vec),
        .token_ret_vec(token_ret_vec), .dl_ack(dl_ack), .origin_vec(origin_vec),
        .token_clear(token_clear), .dl_detect_global(dl_detect_global),
        .dl_report_vld(dl_report_vld), .dl_report_proc(dl_report_proc),
        .dl_report_len(dl_report_len), .dl_report_timeout(dl_report_timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {9'd0, origin_vec, token_clear, dl_detect_global, dl_report_vld,
                dl_report_proc, dl_report_len, dl_report_timeout};
    endfunction

    task automatic wait_report(input string tag);
        rpt_t e;
        int   n = 0;
        while (!dl_report_vld && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_vld"}, dl_report_vld, 1);
        if (dl_report_vld && q.size() > 0) begin
            e = q.pop_front();
            check({tag, "_proc"}, dl_report_proc, e.proc);
            check({tag, "_len"}, dl_report_len, e.len);
            check({tag, "_to"}, dl_report_timeout, e.to);
        end
    endtask

    initial begin
        int cyc;
        reset = 1'b1; dl_detect_vec = '0; token_ret_vec = '0; dl_ack = 1'b0;
        tick(); tick();
        check("reset_outs", all_out(), 0);
        reset = 1'b0;

        // Token loop from origin 2
        dl_detect_vec = 4'b0100;
        tick();
        check("t1_origin", origin_vec, 4'b0100);
        check("t1_global", dl_detect_global, 1);
        q.push_back('{proc: 4'b1101, len: 8'd3, to: 1'b0});
        tick();
        check("t1_origin_pulse", origin_vec, 4'b0000);
        token_ret_vec = 4'b0001; tick();
        token_ret_vec = 4'b1000; tick();
        token_ret_vec = 4'b0100; tick();
        token_ret_vec = 4'b0000;
        check("t1_clear", token_clear, 4'b0100);
        wait_report("t1");
        tick();
        check("t1_clear_pulse", token_clear, 4'b0000);
        check("t1_vld_held", dl_report_vld, 1);
        dl_ack = 1'b1; tick(); dl_ack = 1'b0;
        check("t1_hold_vld", dl_report_vld, 0);
        tick(); tick();
        check("t1_hold_noorigin", origin_vec, 4'b0000);
        check("t1_hold_global", dl_detect_global, 1);
        dl_detect_vec = 4'b0000; tick();
        check("t1_idle_global", dl_detect_global, 0);
        check("t1_idle_proc", dl_report_proc, 4'b1101);
        check("t1_idle_len", dl_report_len, 3);

        // Origin picks lowest bit; dropping bit 3 does not move it
        dl_detect_vec = 4'b1010; tick();
        check("t2_origin", origin_vec, 4'b0010);
        q.push_back('{proc: 4'b0110, len: 8'd2, to: 1'b0});
        tick();
        dl_detect_vec = 4'b0010;
        token_ret_vec = 4'b0100; tick();
        token_ret_vec = 4'b0010; tick();
        token_ret_vec = 4'b0000;
        check("t2_clear", token_clear, 4'b0010);
        wait_report("t2");
        dl_ack = 1'b1; tick(); dl_ack = 1'b0;
        dl_detect_vec = 4'b0000; tick();
        check("t2_idle_global", dl_detect_global, 0);

        // First-cycle return; returns during ORIGIN are ignored
        dl_detect_vec = 4'b0001; tick();
        token_ret_vec = 4'b1111;
        q.push_back('{proc: 4'b0001, len: 8'd1, to: 1'b0});
        tick();
        token_ret_vec = 4'b0001; tick();
        token_ret_vec = 4'b0000;
        check("t3_clear", token_clear, 4'b0001);
        wait_report("t3");
        dl_ack = 1'b1; dl_detect_vec = 4'b0000; tick(); dl_ack = 1'b0;
        tick();
        check("t3_idle_global", dl_detect_global, 0);

        // Timeout: origin 3 never returns
        dl_detect_vec = 4'b1000; tick();
        check("t4_origin", origin_vec, 4'b1000);
        token_ret_vec = 4'b0001;
        q.push_back('{proc: 4'b1001, len: 8'd15, to: 1'b1});
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (token_clear == 4'b0000 && cyc < 100);
        token_ret_vec = 4'b0000;
        check("t4_cycles_to_clear", cyc, 16);
        check("t4_clear", token_clear, 4'b1000);
        wait_report("t4");
        dl_ack = 1'b1; dl_detect_vec = 4'b0000; tick(); dl_ack = 1'b0;
        tick();

        // Reset mid-TRACE
        dl_detect_vec = 4'b0100; tick(); tick(); tick();
        reset = 1'b1; tick();
        check("t5_rst_trace", all_out(), 0);
        reset = 1'b0; tick();
        check("t5_restart_origin", origin_vec, 4'b0100);
        q.push_back('{proc: 4'b0100, len: 8'd1, to: 1'b0});
        tick();
        token_ret_vec = 4'b0100; tick();
        token_ret_vec = 4'b0000;
        wait_report("t5");
        reset = 1'b1; tick();
        check("t5_rst_report", all_out(), 0);
        dl_detect_vec = 4'b0000; reset = 1'b0; tick();
        check("t5_idle", all_out(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
